// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised Fibonacci LFSR generator.
// Tap masks use bit i to mean "state[i] feeds the XOR".
package lfsr_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0245;

  // Maximal-length masks for a left-shifting Fibonacci LFSR, feedback into bit 0.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_100D;
    endcase
    return taps;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with zero-seed substitution and next-state logic.
// Reload has priority over advancing; the state can never become all-zero.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_next
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] load_value;

  assign state_next = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));
  assign load_value = (seed_in == '0) ? SEED : seed_in;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_value;
    end else if (advance) begin
      state_d = state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Random-word generator: collects WIDTH shifts per word and offers each word
// through a valid/ready register, flagging words dropped while one is pending.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             overrun
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             overrun_q, overrun_d;
  logic             advance;
  logic             complete;
  logic             consume;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
    .load       (seed_load),
    .seed_in    (seed_in),
    .state_next (word)
  );

  assign advance  = enable & ~seed_load;
  assign complete = advance & (count_q == LAST);
  assign consume  = rnd_valid_q & rnd_ready;

  // A completing word may replace the pending one only if it is consumed now.
  always_comb begin
    count_d     = count_q;
    rnd_d       = rnd_q;
    rnd_valid_d = rnd_valid_q;
    overrun_d   = overrun_q;
    if (seed_load) begin
      count_d = '0;
    end else if (enable) begin
      count_d = complete ? '0 : count_q + CNT_W'(1);
    end
    if (complete) begin
      if (!rnd_valid_q || consume) begin
        rnd_d       = word;
        rnd_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      rnd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q     <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign overrun   = overrun_q;

endmodule
